// File: rtl/chunked_addsub_if.sv
// Request/response bundle for the chunked adder/subtractor: operands and mode
// flow master -> slave, status and result flow back.
interface chunked_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [1:0]       mode;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, mode, cin, x, y,
        input  busy, done, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  start, mode, cin, x, y,
        output busy, done, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract that ripples CHUNK bits per clock through a carry
// register; result and flags are held from the done pulse until the next start.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    chunked_addsub_if.slave bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               busy_r;
    logic               done_r;
    logic               busy_nx_s;
    logic               done_nx_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   k_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic               neg_r;

    logic               inv_s;
    logic               c0_s;
    logic               last_s;
    logic [IDX_W-1:0]   lsb_s;
    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK-1:0]   s_chunk_s;
    logic               c_chunk_s;
    logic [WIDTH-1:0]   sum_nx_s;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             ci
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Same-sign operands producing an opposite-sign result is exactly
    // carry-into-MSB XOR carry-out-of-MSB, and needs no CHUNK-1 wide sub-add.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

    assign last_s = (k_r == LAST_K);

    // State register with registered busy/done status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Status decode of the upcoming state, registered alongside it
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
            ST_RUN: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            ST_DONE: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Mode decode: operand-B inversion and initial carry
    always_comb begin
        inv_s = 1'b0;
        c0_s  = 1'b0;
        case (bus.mode)
            2'b00: begin
                inv_s = 1'b0;
                c0_s  = 1'b0;
            end
            2'b01: begin
                inv_s = 1'b1;
                c0_s  = 1'b1;
            end
            2'b10: begin
                inv_s = 1'b0;
                c0_s  = bus.cin;
            end
            2'b11: begin
                inv_s = 1'b1;
                c0_s  = bus.cin;
            end
            default: begin
                inv_s = 1'b0;
                c0_s  = 1'b0;
            end
        endcase
    end

    // Current chunk slice, its sum, and the result with that chunk merged in
    always_comb begin
        lsb_s                      = IDX_W'(k_r) * IDX_W'(CHUNK);
        a_chunk_s                  = a_r[lsb_s +: CHUNK];
        b_chunk_s                  = b_r[lsb_s +: CHUNK];
        {c_chunk_s, s_chunk_s}     = chunk_add(a_chunk_s, b_chunk_s, carry_r);
        sum_nx_s                   = sum_r;
        sum_nx_s[lsb_s +: CHUNK]   = s_chunk_s;
    end

    // Operand latch, carry register and chunk counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            k_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.x;
                        b_r     <= bus.y ^ {WIDTH{inv_s}};
                        carry_r <= c0_s;
                        k_r     <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    carry_r <= c_chunk_s;
                    if (last_s) begin
                        k_r <= {CNT_W{1'b0}};
                    end else begin
                        k_r <= k_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    k_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Result and flags; flags only move on the final chunk so they hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b1;
            neg_r  <= 1'b0;
        end else if (state_r == ST_RUN) begin
            sum_r <= sum_nx_s;
            if (last_s) begin
                cout_r <= c_chunk_s;
                ovf_r  <= signed_ovf(a_chunk_s[CHUNK-1], b_chunk_s[CHUNK-1],
                                     s_chunk_s[CHUNK-1]);
                zero_r <= (sum_nx_s == {WIDTH{1'b0}});
                neg_r  <= s_chunk_s[CHUNK-1];
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
    assign bus.neg  = neg_r;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: whole-word arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_chunked_addsub;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chunked_addsub_if #(.WIDTH(W)) bus ();

    chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word unsigned sum for sum/cout, signed integer range for ovf.
    function automatic logic [W+1:0] ref_op(input logic [1:0] md, input logic ci,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic         inv;
        logic         c0;
        logic [W-1:0] be;
        logic [W:0]   full;
        int           res;
        logic         ov;
        case (md)
            2'b00:   begin inv = 1'b0; c0 = 1'b0; end
            2'b01:   begin inv = 1'b1; c0 = 1'b1; end
            2'b10:   begin inv = 1'b0; c0 = ci;   end
            default: begin inv = 1'b1; c0 = ci;   end
        endcase
        be   = inv ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        res  = int'($signed(a)) + int'($signed(be)) + (c0 ? 1 : 0);
        ov   = (res > (2 ** (W - 1)) - 1) || (res < -(2 ** (W - 1)));
        return {ov, full[W], full[W-1:0]};
    endfunction

    // m_cnt: cycles of busy remaining; 1 marks the done cycle.
    int           m_cnt  = 0;
    logic [W+1:0] m_pend = '0;
    logic [W+1:0] m_exp  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_exp <= '0;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                m_cnt  <= N + 1;
                m_pend <= ref_op(bus.mode, bus.cin, bus.x, bus.y);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_exp <= m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_cnt != 0));
        check("done", 32'(bus.done), 32'(m_cnt == 1));
        if (m_cnt <= 1) begin
            check("sum",  32'(bus.sum),  32'(m_exp[W-1:0]));
            check("cout", 32'(bus.cout), 32'(m_exp[W]));
            check("ovf",  32'(bus.ovf),  32'(m_exp[W+1]));
            check("zero", 32'(bus.zero), 32'(m_exp[W-1:0] == '0));
            check("neg",  32'(bus.neg),  32'(m_exp[W-1]));
        end
    end

    task automatic run_op(input string name, input logic [1:0] md, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input logic ezr, input logic eng);
        int lat;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = md; bus.cin = ci; bus.x = a; bus.y = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x = W'($urandom); bus.y = W'($urandom);
        bus.mode = 2'($urandom); bus.cin = 1'($urandom);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'(1));
        check({name, "_lat"},  32'(lat),  32'(N + 1));
        check({name, "_sum"},  32'(bus.sum),  32'(es));
        check({name, "_cout"}, 32'(bus.cout), 32'(eco));
        check({name, "_ovf"},  32'(bus.ovf),  32'(eov));
        check({name, "_zero"}, 32'(bus.zero), 32'(ezr));
        check({name, "_neg"},  32'(bus.neg),  32'(eng));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int dones;
        int idx;
        int q[$];
        logic [W-1:0] done_sum;

        bus.start = 1'b0; bus.mode = 2'b00; bus.cin = 1'b0;
        bus.x = '0; bus.y = '0;

        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_sum",  32'(bus.sum),  32'(0));
        check("rst_zero", 32'(bus.zero), 32'(1));
        rst = 1'b0;

        //      name        mode   cin   x         y         sum       co    ov    zr    ng
        run_op("add",      2'b00, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub",      2'b01, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("add_ovf",  2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("add_wrap", 2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("adc",      2'b10, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sbb",      2'b11, 1'b0, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  2'b01, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sbb_zero", 2'b11, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.x = 16'h1234; bus.y = 16'h0FCD;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.x = 16'hFFFF; bus.y = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        done_sum = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                done_sum = bus.sum;
            end
            @(negedge clk);
        end
        check("busy_ign_dones", 32'(dones), 32'(1));
        check("busy_ign_sum",   32'(done_sum), 32'(16'h2201));
        check("busy_ign_hold",  32'(bus.sum),  32'(16'h2201));

        // reset on the 2nd RUN cycle aborts without a done pulse
        bus.start = 1'b1; bus.x = 16'h0F0F; bus.y = 16'h00F0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_sum",  32'(bus.sum),  32'(0));
        check("abort_zero", 32'(bus.zero), 32'(1));
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));
        run_op("after_abort", 2'b00, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

        // start held high: one result every N+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.x = 16'h0101; bus.y = 16'h0202;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idx++;
            if (bus.done) q.push_back(idx);
        end
        bus.start = 1'b0;
        check("thru_count", 32'(q.size()), 32'(3));
        if (q.size() == 3) begin
            check("thru_first", 32'(q[0]), 32'(N + 1));
            check("thru_gap1",  32'(q[1] - q[0]), 32'(N + 2));
            check("thru_gap2",  32'(q[2] - q[1]), 32'(N + 2));
        end
        repeat (10) @(negedge clk);
        check("thru_sum", 32'(bus.sum), 32'(16'h0303));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
